mem_refill_ctrl: RTL and testbench

MEM_REFILL_CTRL -- requirements
Module: mem_refill_ctrl

---
 rtl/cache_pkg.sv | 23 ++
 rtl/mem_refill_ctrl_if.sv | 47 ++++
 rtl/wr_buffer.sv | 72 +++++++
 rtl/mem_refill_ctrl.sv | 142 ++++++++++++++
 tb/tb_mem_refill_ctrl.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cache_pkg
// Description : Shared types and defaults for the cache refill controller.
// Revision    : 1.0 - initial release
// ============================================================================
package cache_pkg;

   localparam int ADDR_WIDTH         = 32;
   localparam int DATA_WIDTH_DEFAULT = 32;
   localparam int WB_DEPTH_DEFAULT   = 2;

   // Miss-handling controller states
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      DRAIN   = 3'd1,
      RD_REQ  = 3'd2,
      RD_WAIT = 3'd3,
      REFILL  = 3'd4
   } state_t;

endpackage : cache_pkg
`default_nettype wire

// File: rtl/mem_refill_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_refill_ctrl_if
// Description : CPU, cache-refill and main-memory signal bundle for the
//               refill controller. The controller uses the slave view; the
//               CPU/cache/memory environment uses the master view.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_refill_ctrl_if #(
   parameter int DATA_WIDTH = 32
);
   // CPU side
   logic                  cpu_req;
   logic                  cpu_we;
   logic [31:0]           cpu_addr;
   logic [DATA_WIDTH-1:0] cpu_wdata;
   logic                  cache_hit;
   logic                  stall;
   // Cache line write port
   logic                  refill_we;
   logic [31:0]           refill_addr;
   logic [DATA_WIDTH-1:0] refill_data;
   // Main-memory request / response
   logic                  mem_req;
   logic                  mem_we;
   logic [31:0]           mem_addr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic                  mem_gnt;
   logic                  mem_rvalid;
   logic [DATA_WIDTH-1:0] mem_rdata;

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cache_hit,
      input  mem_gnt, mem_rvalid, mem_rdata,
      output stall, refill_we, refill_addr, refill_data,
      output mem_req, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata, cache_hit,
      output mem_gnt, mem_rvalid, mem_rdata,
      input  stall, refill_we, refill_addr, refill_data,
      input  mem_req, mem_we, mem_addr, mem_wdata
   );

endinterface : mem_refill_ctrl_if
`default_nettype wire

// File: rtl/wr_buffer.sv
`default_nettype none
// ============================================================================
// Module      : wr_buffer
// Description : Small FIFO of pending {address, data} store entries. Head
//               entry is presented combinationally; a push is ignored when
//               full and a pop is ignored when empty.
// Revision    : 1.0 - initial release
// ============================================================================
module wr_buffer
   import cache_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
   parameter int DEPTH      = WB_DEPTH_DEFAULT
) (
   input  wire logic                  clk,
   input  wire logic                  rst,
   input  wire logic                  push,
   input  wire logic [ADDR_WIDTH-1:0] push_addr,
   input  wire logic [DATA_WIDTH-1:0] push_data,
   input  wire logic                  pop,
   output logic                       full,
   output logic                       empty,
   output logic [ADDR_WIDTH-1:0]      head_addr,
   output logic [DATA_WIDTH-1:0]      head_data
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int DEPTH_CNT = DEPTH;
   localparam logic [PTR_W:0] FULL_CNT = DEPTH_CNT[PTR_W:0];

   logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
   logic [DATA_WIDTH-1:0] data_mem [DEPTH];
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [PTR_W:0]        count;
   logic                  do_push;
   logic                  do_pop;

   assign full      = (count == FULL_CNT);
   assign empty     = (count == '0);
   assign do_push   = push & ~full;
   assign do_pop    = pop & ~empty;
   assign head_addr = addr_mem[rd_ptr];
   assign head_data = data_mem[rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Entry storage needs no reset: occupancy alone decides validity
   always_ff @(posedge clk) begin
      if (do_push) begin
         addr_mem[wr_ptr] <= push_addr;
         data_mem[wr_ptr] <= push_data;
      end
   end

endmodule : wr_buffer
`default_nettype wire

// File: rtl/mem_refill_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_refill_ctrl
// Description : Direct-mapped cache miss handler with a write-through,
//               no-allocate write buffer. Load misses stall the CPU, drain
//               older stores first, fetch one word and refill the cache.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_refill_ctrl
   import cache_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
   parameter int WB_DEPTH   = WB_DEPTH_DEFAULT
) (
   input  wire logic        clk,
   input  wire logic        rst,
   mem_refill_ctrl_if.slave bus
);

   state_t                  state;
   state_t                  state_nxt;
   logic [ADDR_WIDTH-1:0]   miss_addr;
   logic [DATA_WIDTH-1:0]   refill_data_q;
   logic                    latch_miss;
   logic                    wb_push;
   logic                    wb_pop;
   logic                    wb_full;
   logic                    wb_empty;
   logic [ADDR_WIDTH-1:0]   wb_head_addr;
   logic [DATA_WIDTH-1:0]   wb_head_data;
   logic                    drain_active;
   logic                    stall;
   logic                    mem_req;
   logic                    mem_we;
   logic [ADDR_WIDTH-1:0]   mem_addr;
   logic [DATA_WIDTH-1:0]   mem_wdata;

   // Stores are only accepted while the pipeline is running (IDLE); a store
   // that finds the buffer full is held off by stall and pushes once it clears
   assign wb_push = (state == IDLE) & bus.cpu_req & bus.cpu_we & ~wb_full & ~rst;

   // The memory port belongs to the buffer except while a read is in flight
   assign drain_active = ~wb_empty & (state != RD_REQ) & (state != RD_WAIT);
   assign wb_pop       = drain_active & bus.mem_gnt;

   wr_buffer #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (WB_DEPTH)
   ) u_wr_buffer (
      .clk       (clk),
      .rst       (rst),
      .push      (wb_push),
      .push_addr (bus.cpu_addr),
      .push_data (bus.cpu_wdata),
      .pop       (wb_pop),
      .full      (wb_full),
      .empty     (wb_empty),
      .head_addr (wb_head_addr),
      .head_data (wb_head_data)
   );

   // State register and miss bookkeeping; reset drops any transaction
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         miss_addr     <= '0;
         refill_data_q <= '0;
      end else begin
         state <= state_nxt;
         if (latch_miss) miss_addr <= bus.cpu_addr;
         if ((state == RD_WAIT) && bus.mem_rvalid) refill_data_q <= bus.mem_rdata;
      end
   end

   // Next state, stall and memory request mux
   always_comb begin
      state_nxt  = state;
      stall      = 1'b0;
      latch_miss = 1'b0;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;

      case (state)
         IDLE: begin
            if (bus.cpu_req) begin
               if (bus.cpu_we) begin
                  stall = wb_full;
               end else if (!bus.cache_hit) begin
                  stall      = 1'b1;
                  latch_miss = 1'b1;
                  state_nxt  = wb_empty ? RD_REQ : DRAIN;
               end
            end
         end
         DRAIN: begin
            stall = 1'b1;
            if (wb_empty) state_nxt = RD_REQ;
         end
         RD_REQ: begin
            stall    = 1'b1;
            mem_req  = 1'b1;
            mem_addr = miss_addr;
            if (bus.mem_gnt) state_nxt = RD_WAIT;
         end
         RD_WAIT: begin
            stall = 1'b1;
            if (bus.mem_rvalid) state_nxt = REFILL;
         end
         REFILL: begin
            stall     = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase

      // Head entry stays on the bus until granted, keeping the request stable
      if (drain_active) begin
         mem_req   = 1'b1;
         mem_we    = 1'b1;
         mem_addr  = wb_head_addr;
         mem_wdata = wb_head_data;
      end

      // Stall is partly combinational from CPU inputs, so mask it in reset
      if (rst) stall = 1'b0;
   end

   assign bus.stall       = stall;
   assign bus.refill_we   = (state == REFILL);
   assign bus.refill_addr = miss_addr;
   assign bus.refill_data = refill_data_q;
   assign bus.mem_req     = mem_req;
   assign bus.mem_we      = mem_we;
   assign bus.mem_addr    = mem_addr;
   assign bus.mem_wdata   = mem_wdata;

endmodule : mem_refill_ctrl
`default_nettype wire

// File: tb/tb_mem_refill_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_refill_ctrl
// Description : Directed self-checking bench for mem_refill_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_refill_ctrl;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   mem_refill_ctrl_if #(.DATA_WIDTH(32)) bus ();

   mem_refill_ctrl #(.DATA_WIDTH(32), .WB_DEPTH(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory handshake log, sampled mid-cycle before the completing edge
   logic        log_we[$];
   logic [31:0] log_addr[$];
   logic [31:0] log_data[$];

   // Record each granted memory request
   always @(negedge clk) begin
      if (rst === 1'b0 && bus.mem_req === 1'b1 && bus.mem_gnt === 1'b1) begin
         log_we.push_back(bus.mem_we);
         log_addr.push_back(bus.mem_addr);
         log_data.push_back(bus.mem_wdata);
      end
   end

   // Absolute guard against a hung run
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.cpu_req    = 1'b0;
      bus.cpu_we     = 1'b0;
      bus.cpu_addr   = '0;
      bus.cpu_wdata  = '0;
      bus.cache_hit  = 1'b0;
      bus.mem_gnt    = 1'b0;
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = '0;
   endtask

   task automatic clear_log();
      log_we.delete();
      log_addr.delete();
      log_data.delete();
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b1;
      tick();
      tick();
      #1;
      n_checks++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", bus.stall); end
      n_checks++; if (bus.refill_we !== 1'b0) begin n_fail++; $display("FAIL reset_refill_we: got %b expected 0", bus.refill_we); end
      n_checks++; if (bus.mem_req !== 1'b0 || bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got req=%b we=%b expected 0/0", bus.mem_req, bus.mem_we); end
      n_checks++; if (bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_mem_bus: got addr=%h data=%h expected 0", bus.mem_addr, bus.mem_wdata); end
      n_checks++; if (bus.refill_addr !== 32'h0 || bus.refill_data !== 32'h0) begin n_fail++; $display("FAIL reset_refill_bus: got addr=%h data=%h expected 0", bus.refill_addr, bus.refill_data); end
      tick();
      rst = 1'b0;
   endtask

   task automatic test_load_hit();
      tick();
      bus.cpu_req   = 1'b1;
      bus.cpu_we    = 1'b0;
      bus.cpu_addr  = 32'h40;
      bus.cache_hit = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_checks++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL hit_stall[%0d]: got %b expected 0", i, bus.stall); end
         n_checks++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL hit_mem_req[%0d]: got %b expected 0", i, bus.mem_req); end
         n_checks++; if (bus.refill_we !== 1'b0) begin n_fail++; $display("FAIL hit_refill_we[%0d]: got %b expected 0", i, bus.refill_we); end
         tick();
      end
      idle_inputs();
   endtask

   task automatic test_load_miss();
      int stalls;
      stalls = 0;
      tick();
      bus.mem_gnt    = 1'b1;
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 32'hDEADBEEF;
      bus.cpu_req    = 1'b1;
      bus.cpu_we     = 1'b0;
      bus.cpu_addr   = 32'h100;
      bus.cache_hit  = 1'b0;
      #1;
      n_checks++; if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL miss_detect_stall: got %b expected 1", bus.stall); end
      tick(); #1;
      if (bus.stall === 1'b1) stalls++;
      n_checks++; if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 32'h100) begin n_fail++; $display("FAIL miss_rd_req: got req=%b we=%b addr=%h expected 1/0/00000100", bus.mem_req, bus.mem_we, bus.mem_addr); end
      tick(); #1;
      if (bus.stall === 1'b1) stalls++;
      n_checks++; if (bus.refill_we !== 1'b0) begin n_fail++; $display("FAIL miss_wait_refill_we: got %b expected 0", bus.refill_we); end
      tick(); #1;
      if (bus.stall === 1'b1) stalls++;
      n_checks++; if (bus.refill_we !== 1'b1 || bus.refill_addr !== 32'h100 || bus.refill_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL miss_refill: got we=%b addr=%h data=%h expected 1/00000100/deadbeef", bus.refill_we, bus.refill_addr, bus.refill_data); end
      bus.cache_hit = 1'b1;
      tick(); #1;
      n_checks++; if (stalls != 3) begin n_fail++; $display("FAIL miss_penalty: got %0d stalled cycles expected 3", stalls); end
      n_checks++; if (bus.stall !== 1'b0 || bus.refill_we !== 1'b0) begin n_fail++; $display("FAIL miss_replay: got stall=%b refill_we=%b expected 0/0", bus.stall, bus.refill_we); end
      idle_inputs();
   endtask

   task automatic test_store_full();
      int k;
      clear_log();
      tick();
      bus.mem_gnt   = 1'b0;
      bus.cpu_req   = 1'b1;
      bus.cpu_we    = 1'b1;
      bus.cpu_addr  = 32'h10;
      bus.cpu_wdata = 32'h11;
      #1;
      n_checks++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL store1_stall: got %b expected 0", bus.stall); end
      tick();
      bus.cpu_addr  = 32'h14;
      bus.cpu_wdata = 32'h22;
      #1;
      n_checks++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL store2_stall: got %b expected 0", bus.stall); end
      n_checks++; if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 32'h10) begin n_fail++; $display("FAIL store_drain_head: got req=%b we=%b addr=%h expected 1/1/00000010", bus.mem_req, bus.mem_we, bus.mem_addr); end
      tick();
      bus.cpu_addr  = 32'h18;
      bus.cpu_wdata = 32'h33;
      #1;
      n_checks++; if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL store3_full_stall: got %b expected 1", bus.stall); end
      tick(); #1;
      n_checks++; if (bus.stall !== 1'b1 || bus.mem_addr !== 32'h10 || bus.mem_wdata !== 32'h11) begin n_fail++; $display("FAIL store_hold: got stall=%b addr=%h data=%h expected 1/00000010/00000011", bus.stall, bus.mem_addr, bus.mem_wdata); end
      bus.mem_gnt = 1'b1;
      tick(); #1;
      n_checks++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL store3_release: got stall=%b expected 0", bus.stall); end
      tick();
      bus.cpu_req = 1'b0;
      k = 0;
      #1;
      while (bus.mem_req === 1'b1 && k < 10) begin tick(); #1; k++; end
      n_checks++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL store_drain_timeout: got mem_req=%b expected 0", bus.mem_req); end
      n_checks++; if (log_addr.size() != 3) begin n_fail++; $display("FAIL store_write_count: got %0d expected 3", log_addr.size()); end
      if (log_addr.size() == 3) begin
         n_checks++; if (log_addr[0] !== 32'h10 || log_data[0] !== 32'h11) begin n_fail++; $display("FAIL store_order0: got %h=%h expected 00000010=00000011", log_addr[0], log_data[0]); end
         n_checks++; if (log_addr[1] !== 32'h14 || log_data[1] !== 32'h22) begin n_fail++; $display("FAIL store_order1: got %h=%h expected 00000014=00000022", log_addr[1], log_data[1]); end
         n_checks++; if (log_addr[2] !== 32'h18 || log_data[2] !== 32'h33) begin n_fail++; $display("FAIL store_order2: got %h=%h expected 00000018=00000033", log_addr[2], log_data[2]); end
      end
      idle_inputs();
   endtask

   task automatic test_raw_order();
      int k;
      clear_log();
      tick();
      bus.mem_gnt   = 1'b0;
      bus.cpu_req   = 1'b1;
      bus.cpu_we    = 1'b1;
      bus.cpu_addr  = 32'h20;
      bus.cpu_wdata = 32'h5;
      #1;
      n_checks++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL raw_store_stall: got %b expected 0", bus.stall); end
      tick();
      bus.cpu_we    = 1'b0;
      bus.cache_hit = 1'b0;
      #1;
      n_checks++; if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL raw_miss_stall: got %b expected 1", bus.stall); end
      tick(); #1;
      n_checks++; if (bus.stall !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 32'h20) begin n_fail++; $display("FAIL raw_drain: got stall=%b we=%b addr=%h expected 1/1/00000020", bus.stall, bus.mem_we, bus.mem_addr); end
      bus.mem_gnt    = 1'b1;
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 32'h5;
      k = 0;
      while (bus.refill_we !== 1'b1 && k < 20) begin tick(); #1; k++; end
      n_checks++; if (bus.refill_we !== 1'b1) begin n_fail++; $display("FAIL raw_refill_timeout: got refill_we=%b expected 1", bus.refill_we); end
      n_checks++; if (bus.refill_addr !== 32'h20 || bus.refill_data !== 32'h5) begin n_fail++; $display("FAIL raw_refill: got addr=%h data=%h expected 00000020/00000005", bus.refill_addr, bus.refill_data); end
      bus.cache_hit = 1'b1;
      tick(); #1;
      idle_inputs();
      n_checks++; if (log_we.size() != 2) begin n_fail++; $display("FAIL raw_txn_count: got %0d expected 2", log_we.size()); end
      if (log_we.size() == 2) begin
         n_checks++; if (log_we[0] !== 1'b1 || log_addr[0] !== 32'h20 || log_data[0] !== 32'h5) begin n_fail++; $display("FAIL raw_first_is_write: got we=%b addr=%h data=%h expected 1/00000020/00000005", log_we[0], log_addr[0], log_data[0]); end
         n_checks++; if (log_we[1] !== 1'b0 || log_addr[1] !== 32'h20) begin n_fail++; $display("FAIL raw_second_is_read: got we=%b addr=%h expected 0/00000020", log_we[1], log_addr[1]); end
      end
   endtask

   task automatic test_gnt_hold();
      int k;
      tick();
      bus.mem_gnt   = 1'b0;
      bus.cpu_req   = 1'b1;
      bus.cpu_we    = 1'b0;
      bus.cpu_addr  = 32'h200;
      bus.cache_hit = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick(); #1;
         n_checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h200 || bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL hold_req[%0d]: got req=%b we=%b addr=%h expected 1/0/00000200", i, bus.mem_req, bus.mem_we, bus.mem_addr); end
         n_checks++; if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL hold_stall[%0d]: got %b expected 1", i, bus.stall); end
      end
      bus.mem_gnt    = 1'b1;
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 32'hCAFE0001;
      k = 0;
      while (bus.refill_we !== 1'b1 && k < 20) begin tick(); #1; k++; end
      n_checks++; if (bus.refill_we !== 1'b1 || bus.refill_data !== 32'hCAFE0001) begin n_fail++; $display("FAIL hold_refill: got we=%b data=%h expected 1/cafe0001", bus.refill_we, bus.refill_data); end
      bus.cache_hit = 1'b1;
      tick();
      idle_inputs();
   endtask

   task automatic test_reset_mid_miss();
      int k;
      tick();
      bus.mem_gnt   = 1'b1;
      bus.cpu_req   = 1'b1;
      bus.cpu_we    = 1'b0;
      bus.cpu_addr  = 32'h300;
      bus.cache_hit = 1'b0;
      tick();
      tick(); #1;
      n_checks++; if (bus.stall !== 1'b1 || bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL mid_rd_wait: got stall=%b req=%b expected 1/0", bus.stall, bus.mem_req); end
      bus.cpu_req = 1'b0;
      rst = 1'b1;
      #1;
      n_checks++; if (bus.stall !== 1'b0 || bus.refill_we !== 1'b0 || bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ctrl: got stall=%b refill_we=%b req=%b expected 0/0/0", bus.stall, bus.refill_we, bus.mem_req); end
      n_checks++; if (bus.refill_addr !== 32'h0 || bus.mem_addr !== 32'h0) begin n_fail++; $display("FAIL mid_rst_addr: got refill_addr=%h mem_addr=%h expected 0/0", bus.refill_addr, bus.mem_addr); end
      tick();
      rst            = 1'b0;
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 32'h0BAD0BAD;
      for (int i = 0; i < 3; i++) begin
         tick(); #1;
         n_checks++; if (bus.refill_we !== 1'b0 || bus.stall !== 1'b0) begin n_fail++; $display("FAIL mid_stale_rvalid[%0d]: got refill_we=%b stall=%b expected 0/0", i, bus.refill_we, bus.stall); end
      end
      bus.mem_rdata = 32'h12345678;
      bus.cpu_req   = 1'b1;
      bus.cpu_addr  = 32'h340;
      k = 0;
      #1;
      while (bus.refill_we !== 1'b1 && k < 20) begin tick(); #1; k++; end
      n_checks++; if (bus.refill_we !== 1'b1 || bus.refill_addr !== 32'h340 || bus.refill_data !== 32'h12345678) begin n_fail++; $display("FAIL mid_next_miss: got we=%b addr=%h data=%h expected 1/00000340/12345678", bus.refill_we, bus.refill_addr, bus.refill_data); end
      bus.cache_hit = 1'b1;
      tick();
      idle_inputs();
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst      = 1'b1;
      idle_inputs();
      test_reset();
      test_load_hit();
      test_load_miss();
      test_store_full();
      test_raw_order();
      test_gnt_hold();
      test_reset_mid_miss();
      tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_mem_refill_ctrl
`default_nettype wire
